// File: rtl/reset_sequencer.sv
// Ordered reset release: holds all domain resets, then frees them one stage at a time, gated on ready + settle gap.
// Latency: stage 0 freed HOLD_CYCLES edges after reset; each later stage SETTLE_CYCLES edges after prior ready; all outputs registered.
// Backpressure: none; a stage not reporting ready within TIMEOUT_CYCLES re-asserts every reset and latches the stage index.
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 20,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int K_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  seq_done,
    output logic                  seq_error,
    output logic [K_W-1:0]        error_stage
);

    localparam int MAX_HS  = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int MAX_ALL = (MAX_HS > TIMEOUT_CYCLES) ? MAX_HS : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [K_W-1:0]   K_LAST       = K_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        HOLD,
        WAIT_READY,
        SETTLE,
        DONE,
        ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [K_W-1:0]          k_nxt;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]   stage_reset_q, stage_reset_d;
    logic                    seq_done_q, seq_done_d;
    logic                    seq_error_q, seq_error_d;
    logic [K_W-1:0]          error_stage_q, error_stage_d;

    assign k_nxt = k_q + K_W'(1);

    // State and output registers; reset asserts every domain reset immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HOLD;
            k_q           <= '0;
            cnt_q         <= '0;
            stage_reset_q <= '1;
            seq_done_q    <= 1'b0;
            seq_error_q   <= 1'b0;
            error_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            stage_reset_q <= stage_reset_d;
            seq_done_q    <= seq_done_d;
            seq_error_q   <= seq_error_d;
            error_stage_q <= error_stage_d;
        end
    end

    // Next-state logic; soft restart overrides every transition, and ready beats the timeout on the same edge.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        cnt_d         = cnt_q + CNT_W'(1);
        stage_reset_d = stage_reset_q;
        seq_done_d    = seq_done_q;
        seq_error_d   = seq_error_q;
        error_stage_d = error_stage_q;

        if (soft_reset_req) begin
            state_d       = HOLD;
            k_d           = '0;
            cnt_d         = '0;
            stage_reset_d = '1;
            seq_done_d    = 1'b0;
            seq_error_d   = 1'b0;
            error_stage_d = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    stage_reset_d = '1;
                    if (cnt_q == HOLD_LAST) begin
                        stage_reset_d[0] = 1'b0;
                        k_d              = '0;
                        cnt_d            = '0;
                        state_d          = WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (stage_ready[k_q]) begin
                        cnt_d = '0;
                        if (k_q == K_LAST) begin
                            state_d    = DONE;
                            seq_done_d = 1'b1;
                        end else begin
                            state_d = SETTLE;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d       = ERROR;
                        cnt_d         = '0;
                        stage_reset_d = '1;
                        seq_error_d   = 1'b1;
                        error_stage_d = k_q;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        stage_reset_d[k_nxt] = 1'b0;
                        k_d                  = k_nxt;
                        cnt_d                = '0;
                        state_d              = WAIT_READY;
                    end
                end
                DONE: begin
                    cnt_d = cnt_q;
                end
                ERROR: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d       = HOLD;
                    k_d           = '0;
                    cnt_d         = '0;
                    stage_reset_d = '1;
                end
            endcase
        end
    end

    assign stage_reset = stage_reset_q;
    assign seq_done    = seq_done_q;
    assign seq_error   = seq_error_q;
    assign error_stage = error_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_reset_req = 1'b0;
    logic [2:0] stage_ready = 3'b000;
    logic [2:0] stage_reset;
    logic       seq_done;
    logic       seq_error;
    logic [1:0] error_stage;

    int errors = 0;
    int checks = 0;

    // edge bookkeeping relative to a reference point (rst release or soft pulse edge)
    int         e;
    int         fall_e[3];
    int         done_e;
    int         err_e;
    logic [2:0] prev;

    reset_sequencer #(
        .NUM_STAGES(3),
        .HOLD_CYCLES(20),
        .SETTLE_CYCLES(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .soft_reset_req(soft_reset_req),
        .stage_ready(stage_ready),
        .stage_reset(stage_reset),
        .seq_done(seq_done),
        .seq_error(seq_error),
        .error_stage(error_stage)
    );

    always #5 clk = ~clk;

    task automatic rec_clear();
        e = 0;
        for (int i = 0; i < 3; i++) fall_e[i] = -1;
        done_e = -1;
        err_e  = -1;
        prev   = stage_reset;
    endtask

    task automatic run_to(input int target);
        while (e < target) begin
            @(posedge clk);
            #1;
            e++;
            for (int i = 0; i < 3; i++)
                if (prev[i] && !stage_reset[i] && fall_e[i] < 0) fall_e[i] = e;
            prev = stage_reset;
            if (seq_done && done_e < 0) done_e = e;
            if (seq_error && err_e < 0) err_e = e;
        end
    endtask

    task automatic start_seq(input logic [2:0] rdy);
        rst = 1'b1;
        soft_reset_req = 1'b0;
        stage_ready = rdy;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rec_clear();
    endtask

    task automatic pulse_soft();
        @(negedge clk);
        soft_reset_req = 1'b1;
        @(posedge clk);
        #1;
        soft_reset_req = 1'b0;
        rec_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stage_reset !== 3'b111) begin errors++; $display("FAIL reset_stage_reset got=%b want=111", stage_reset); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done got=%b want=0", seq_done); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL reset_seq_error got=%b want=0", seq_error); end
        checks++; if (error_stage !== 2'd0) begin errors++; $display("FAIL reset_error_stage got=%0d want=0", error_stage); end
    endtask

    task automatic test_normal_seq();
        start_seq(3'b111);
        run_to(40);
        checks++; if (fall_e[0] != 20) begin errors++; $display("FAIL norm_fall0 got=%0d want=20", fall_e[0]); end
        checks++; if (fall_e[1] != 25) begin errors++; $display("FAIL norm_fall1 got=%0d want=25", fall_e[1]); end
        checks++; if (fall_e[2] != 30) begin errors++; $display("FAIL norm_fall2 got=%0d want=30", fall_e[2]); end
        checks++; if (done_e != 31) begin errors++; $display("FAIL norm_done_edge got=%0d want=31", done_e); end
        checks++; if (err_e != -1) begin errors++; $display("FAIL norm_no_error got=%0d want=-1", err_e); end
        checks++; if (stage_reset !== 3'b000) begin errors++; $display("FAIL norm_final_reset got=%b want=000", stage_reset); end
    endtask

    task automatic test_soft_in_done();
        pulse_soft();
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL softdone_done_clear got=%b want=0", seq_done); end
        checks++; if (stage_reset !== 3'b111) begin errors++; $display("FAIL softdone_reassert got=%b want=111", stage_reset); end
        run_to(35);
        checks++; if (done_e != 31) begin errors++; $display("FAIL softdone_done_edge got=%0d want=31", done_e); end
        stage_ready = 3'b110;
        run_to(45);
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL done_ignore_ready got=%b want=1", seq_done); end
        checks++; if (stage_reset !== 3'b000) begin errors++; $display("FAIL done_ignore_reset got=%b want=000", stage_reset); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL done_ignore_error got=%b want=0", seq_error); end
    endtask

    task automatic test_soft_held();
        stage_ready = 3'b111;
        @(negedge clk);
        soft_reset_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        soft_reset_req = 1'b0;
        rec_clear();
        run_to(22);
        checks++; if (fall_e[0] != 20) begin errors++; $display("FAIL held_fall0 got=%0d want=20", fall_e[0]); end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        start_seq(3'b101);
        run_to(130);
        checks++; if (fall_e[1] != 25) begin errors++; $display("FAIL to_fall1 got=%0d want=25", fall_e[1]); end
        checks++; if (err_e != 125) begin errors++; $display("FAIL to_err_edge got=%0d want=125", err_e); end
        checks++; if (fall_e[2] != -1) begin errors++; $display("FAIL to_no_fall2 got=%0d want=-1", fall_e[2]); end
        checks++; if (error_stage !== 2'd1) begin errors++; $display("FAIL to_error_stage got=%0d want=1", error_stage); end
        checks++; if (stage_reset !== 3'b111) begin errors++; $display("FAIL to_reset_all got=%b want=111", stage_reset); end
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (seq_error !== 1'b1 || stage_reset !== 3'b111 || error_stage !== 2'd1 || seq_done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL to_error_hold got=%0d bad cycles want=0", bad); end
    endtask

    task automatic test_soft_from_error();
        stage_ready = 3'b111;
        pulse_soft();
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL softerr_error got=%b want=0", seq_error); end
        checks++; if (error_stage !== 2'd0) begin errors++; $display("FAIL softerr_stage got=%0d want=0", error_stage); end
        checks++; if (stage_reset !== 3'b111) begin errors++; $display("FAIL softerr_reset got=%b want=111", stage_reset); end
        run_to(35);
        checks++; if (fall_e[0] != 20) begin errors++; $display("FAIL softerr_fall0 got=%0d want=20", fall_e[0]); end
        checks++; if (fall_e[1] != 25) begin errors++; $display("FAIL softerr_fall1 got=%0d want=25", fall_e[1]); end
        checks++; if (fall_e[2] != 30) begin errors++; $display("FAIL softerr_fall2 got=%0d want=30", fall_e[2]); end
        checks++; if (done_e != 31) begin errors++; $display("FAIL softerr_done_edge got=%0d want=31", done_e); end
    endtask

    task automatic test_timeout_boundary();
        start_seq(3'b101);
        run_to(124);
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL bound_pre_error got=%b want=0", seq_error); end
        stage_ready = 3'b111;
        run_to(135);
        checks++; if (err_e != -1) begin errors++; $display("FAIL bound_no_error got=%0d want=-1", err_e); end
        checks++; if (fall_e[2] != 129) begin errors++; $display("FAIL bound_fall2 got=%0d want=129", fall_e[2]); end
        checks++; if (done_e != 130) begin errors++; $display("FAIL bound_done_edge got=%0d want=130", done_e); end
    endtask

    task automatic test_async_rst();
        start_seq(3'b111);
        run_to(22);
        checks++; if (stage_reset !== 3'b110) begin errors++; $display("FAIL arst_mid_settle got=%b want=110", stage_reset); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (stage_reset !== 3'b111) begin errors++; $display("FAIL arst_immediate got=%b want=111", stage_reset); end
        @(negedge clk);
        rst = 1'b0;
        rec_clear();
        run_to(26);
        checks++; if (fall_e[0] != 20) begin errors++; $display("FAIL arst_fall0 got=%0d want=20", fall_e[0]); end
        checks++; if (fall_e[1] != 25) begin errors++; $display("FAIL arst_fall1 got=%0d want=25", fall_e[1]); end
    endtask

    initial begin
        test_reset();
        test_normal_seq();
        test_soft_in_done();
        test_soft_held();
        test_timeout();
        test_soft_from_error();
        test_timeout_boundary();
        test_async_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
